avalon_mm_mem_tester: RTL
=========================

Name: avalon_mm_mem_tester

Overview:
- Avalon-MM master that drives an on-chip memory slave port from the initiator side.
- On a start pulse it writes a deterministic pattern into a word-addressed region, then reads the region back and compares each word.
- Reports an error count and the first failing word address.
- Sits beside the Nios II on the Qsys interconnect as a built-in memory self-test and bring-up engine.

Parameters:
- ADDR_W, 10, word-address width of the target memory (1024 words)
- DATA_W, 32, data width; byteenable width is DATA_W/8
- ERR_W, 16, width of the saturating error counter
- TIMEOUT, 255, maximum cycles to wait for readdatavalid before declaring a timeout

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- start  in  1  single-cycle pulse; sampled only in IDLE
- base_addr  in  ADDR_W  first word address; latched on start
- num_words  in  ADDR_W+1  region length in words (0 to 2^ADDR_W); latched on start
- seed  in  DATA_W  pattern seed; latched on start
- busy  out  1  high from the cycle after start until done asserts
- done  out  1  one-cycle pulse at the end of a run
- pass  out  1  high when err_count==0 and no timeout; valid from done until the next start
- timeout  out  1  sticky until the next start
- err_count  out  ERR_W  saturating mismatch count
- first_err_addr  out  ADDR_W  word address of the first mismatch
- avm_address  out  ADDR_W+2  byte address = word address << 2
- avm_read  out  1  Avalon-MM read request
- avm_write  out  1  Avalon-MM write request
- avm_writedata  out  DATA_W  write data
- avm_byteenable  out  DATA_W/8  always all ones
- avm_waitrequest  in  1  slave stall
- avm_readdata  in  DATA_W  read data
- avm_readdatavalid  in  1  read data qualifier

Behaviour:
- Reset values: all outputs 0 except avm_byteenable, which is all ones. State is IDLE.
- Pattern for index i: P(i) = seed + i, modulo 2^DATA_W.
- Word address for index i: (base_addr + i) mod 2^ADDR_W. Wrap-around is legal and silent.
- IDLE state:
  - On start with num_words==0: pulse done the next cycle, pass=1, no bus traffic, busy stays 0.
  - On start otherwise: latch inputs, clear err_count, first_err_addr and timeout; set i=0; go to WR.
- WR state:
  - Drive avm_write=1 with address and data for index i.
  - Hold address, data and avm_write stable while avm_waitrequest=1.
  - A write is accepted in any cycle where avm_write=1 and avm_waitrequest=0; i then increments.
  - After the last accept, set i=0 and go to RD_REQ. Back-to-back writes are issued with no idle cycle.
- RD_REQ state:
  - Drive avm_read=1 and hold it while avm_waitrequest=1.
  - On accept, deassert avm_read and go to RD_WAIT with the timeout counter cleared.
  - Only one read is outstanding at a time.
- RD_WAIT state:
  - On avm_readdatavalid, compare avm_readdata with P(i).
  - On mismatch: increment err_count, saturating at all ones. If this is the first mismatch, capture first_err_addr.
  - If i is not the last index: increment i and go to RD_REQ. If it is the last index: go to FIN.
  - If TIMEOUT cycles pass with no readdatavalid: set timeout=1 and go to FIN. The remaining reads are abandoned.
  - readdatavalid arriving outside RD_WAIT is ignored.
- FIN state: done=1 for one cycle, busy=0, pass computed as above, then return to IDLE.
- start while busy is ignored.
- Asynchronous reset mid-run: the bus request drops immediately and all state clears. A partially written region is not restored.
- Latency with zero-wait-state writes: N write cycles. Reads take (1 + slave read latency) cycles per word, plus 1 FIN cycle.

Decomposition:
- Shared package avalon_mm_tester_pkg contains:
  - the state enum (IDLE, WR, RD_REQ, RD_WAIT, FIN)
  - the BYTEEN_ALL constant
  - a pattern function pat(seed, i)
- Natural sub-module: avalon_mm_tester_checker. It handles the compare, saturating err_count, first-error capture and the timeout counter. The FSM and bus driver stay in the top level.

Test Plan:
- Zero-wait memory model (read latency 1); base=0x000, num_words=16, seed=0xA5A50000 -> 16 writes at byte addresses 0x000–0x03C with data 0xA5A50000–0xA5A5000F, 16 reads, done pulse, pass=1, err_count=0.
- Same run, model forces bit 0 of the word at word address 5 -> err_count=1, first_err_addr=5, pass=0.
- base=0x3FE, num_words=4 -> writes hit word addresses 0x3FE, 0x3FF, 0x000, 0x001 (byte addresses 0xFF8, 0xFFC, 0x000, 0x004), pass=1.
- Model asserts waitrequest for 3 cycles on every request -> address, data and request held stable throughout, each transaction completes once, pass=1.
- Model never returns readdatavalid -> timeout=1 after 255 cycles in RD_WAIT, done pulses, pass=0. A second start pulse during the run is ignored.
- reset_n asserted mid-WR on word 7 -> avm_write=0 asynchronously and busy=0. After release, start with num_words=0 -> done on the next cycle with no bus activity.

Source files
------------

// File: rtl/avalon_mm_tester_pkg.sv
// Shared definitions for the Avalon-MM memory tester.
//   tester_state_e : run-sequencing states of the tester FSM
//   BYTEEN_ALL     : all-lanes-on byteenable source, sliced to DATA_W/8 by users
//   pat()          : test pattern for word index i, seed + i (truncated by caller)
package avalon_mm_tester_pkg;

   typedef enum logic [2:0] {
      IDLE    = 3'd0,
      WR      = 3'd1,
      RD_REQ  = 3'd2,
      RD_WAIT = 3'd3,
      FIN     = 3'd4
   } tester_state_e;

   // Wide enough for any practical data bus; users take the low DATA_W/8 bits.
   localparam int                       BYTEEN_MAX_W = 128;
   localparam logic [BYTEEN_MAX_W-1:0]  BYTEEN_ALL   = {BYTEEN_MAX_W{1'b1}};

   // Computed at 64 bits; truncating to DATA_W gives the modulo-2^DATA_W pattern.
   function automatic logic [63:0] pat(input logic [63:0] seed, input logic [63:0] idx);
      pat = seed + idx;
   endfunction

endpackage

// File: rtl/avalon_mm_tester_checker.sv
// Read-back checker for the Avalon-MM memory tester.
// Ports:
//   clk, rst_n      : clock, asynchronous active-low reset
//   clear           : accepted start; clears all results
//   arm             : read request accepted; restarts the readdatavalid timeout
//   in_wait         : FSM is waiting for read data
//   rdv, rdata      : readdatavalid / readdata from the slave
//   exp_data        : expected pattern for the current index
//   word_addr       : word address of the current index
//   err_count       : saturating mismatch count (registered)
//   first_err_addr  : word address of the first mismatch (registered)
//   timeout         : sticky timeout flag (registered)
//   mismatch        : this cycle's read data differs from expected
//   timeout_hit     : this cycle is the last allowed wait cycle without data
module avalon_mm_tester_checker
   import avalon_mm_tester_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int ERR_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clear,
   input  logic              arm,
   input  logic              in_wait,
   input  logic              rdv,
   input  logic [DATA_W-1:0] rdata,
   input  logic [DATA_W-1:0] exp_data,
   input  logic [ADDR_W-1:0] word_addr,
   output logic [ERR_W-1:0]  err_count,
   output logic [ADDR_W-1:0] first_err_addr,
   output logic              timeout,
   output logic              mismatch,
   output logic              timeout_hit
);

   localparam int               TMO_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
   localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT - 1);
   localparam logic [ERR_W-1:0] ERR_MAX  = {ERR_W{1'b1}};
   localparam logic [TMO_W-1:0] TMO_ONE  = {{(TMO_W-1){1'b0}}, 1'b1};

   logic [ERR_W-1:0]  err_count_r;
   logic [ADDR_W-1:0] first_err_addr_r;
   logic              timeout_r;
   logic [TMO_W-1:0]  tmo_cnt_r;

   // Classify the current wait cycle: data compare or timeout expiry.
   always_comb begin
      mismatch    = 1'b0;
      timeout_hit = 1'b0;
      if (in_wait && rdv) begin
         mismatch = (rdata != exp_data);
      end else if (in_wait) begin
         // The counter reaches TIMEOUT-1 on the TIMEOUT-th cycle without data.
         timeout_hit = (tmo_cnt_r == TMO_LAST);
      end else begin
         mismatch    = 1'b0;
         timeout_hit = 1'b0;
      end
   end

   // Result registers and readdatavalid wait counter.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         err_count_r      <= {ERR_W{1'b0}};
         first_err_addr_r <= {ADDR_W{1'b0}};
         timeout_r        <= 1'b0;
         tmo_cnt_r        <= {TMO_W{1'b0}};
      end else if (clear) begin
         err_count_r      <= {ERR_W{1'b0}};
         first_err_addr_r <= {ADDR_W{1'b0}};
         timeout_r        <= 1'b0;
         tmo_cnt_r        <= {TMO_W{1'b0}};
      end else begin
         if (arm) begin
            tmo_cnt_r <= {TMO_W{1'b0}};
         end else if (in_wait && !rdv && !timeout_hit) begin
            tmo_cnt_r <= tmo_cnt_r + TMO_ONE;
         end else begin
            tmo_cnt_r <= tmo_cnt_r;
         end
         if (mismatch) begin
            // A zero count means no earlier mismatch, since the counter saturates.
            if (err_count_r == {ERR_W{1'b0}}) begin
               first_err_addr_r <= word_addr;
            end else begin
               first_err_addr_r <= first_err_addr_r;
            end
            if (err_count_r != ERR_MAX) begin
               err_count_r <= err_count_r + {{(ERR_W-1){1'b0}}, 1'b1};
            end else begin
               err_count_r <= err_count_r;
            end
         end else begin
            err_count_r      <= err_count_r;
            first_err_addr_r <= first_err_addr_r;
         end
         if (timeout_hit) begin
            timeout_r <= 1'b1;
         end else begin
            timeout_r <= timeout_r;
         end
      end
   end

   assign err_count      = err_count_r;
   assign first_err_addr = first_err_addr_r;
   assign timeout        = timeout_r;

endmodule

// File: rtl/avalon_mm_mem_tester.sv
// Avalon-MM memory self-test master: writes seed+i to a word region, reads it
// back one word at a time and reports mismatches and read timeouts.
// Ports:
//   clk, reset_n                : clock, asynchronous active-low reset
//   start, base_addr, num_words, seed : run request and parameters (latched in IDLE)
//   busy, done, pass, timeout   : run status
//   err_count, first_err_addr   : mismatch results
//   avm_*                       : Avalon-MM master port (byte addressed, word aligned)
module avalon_mm_mem_tester
   import avalon_mm_tester_pkg::*;
#(
   parameter int ADDR_W  = 10,
   parameter int DATA_W  = 32,
   parameter int ERR_W   = 16,
   parameter int TIMEOUT = 255
) (
   input  logic                clk,
   input  logic                reset_n,
   input  logic                start,
   input  logic [ADDR_W-1:0]   base_addr,
   input  logic [ADDR_W:0]     num_words,
   input  logic [DATA_W-1:0]   seed,
   output logic                busy,
   output logic                done,
   output logic                pass,
   output logic                timeout,
   output logic [ERR_W-1:0]    err_count,
   output logic [ADDR_W-1:0]   first_err_addr,
   output logic [ADDR_W+1:0]   avm_address,
   output logic                avm_read,
   output logic                avm_write,
   output logic [DATA_W-1:0]   avm_writedata,
   output logic [DATA_W/8-1:0] avm_byteenable,
   input  logic                avm_waitrequest,
   input  logic [DATA_W-1:0]   avm_readdata,
   input  logic                avm_readdatavalid
);

   localparam logic [ADDR_W:0] IDX_ZERO = {(ADDR_W+1){1'b0}};
   localparam logic [ADDR_W:0] IDX_ONE  = {{ADDR_W{1'b0}}, 1'b1};

   tester_state_e     state_r, state_nxt_s;
   logic [ADDR_W:0]   idx_r, idx_nxt_s, idx_inc_s;
   logic [ADDR_W-1:0] base_r, base_nxt_s;
   logic [ADDR_W:0]   num_r, num_nxt_s;
   logic [DATA_W-1:0] seed_r, seed_nxt_s;
   logic              busy_r, busy_nxt_s;
   logic              done_r, done_nxt_s;
   logic              pass_r, pass_nxt_s;
   logic [ADDR_W+1:0] avm_address_r, addr_nxt_s;
   logic              avm_read_r, rd_nxt_s;
   logic              avm_write_r, wr_nxt_s;
   logic [DATA_W-1:0] avm_writedata_r, data_nxt_s;
   logic [ADDR_W-1:0] word_cur_s, word_inc_s;
   logic [DATA_W-1:0] pat_cur_s, pat_inc_s;
   logic              last_s;
   logic              clear_s, arm_s, in_wait_s;
   logic              mismatch_s, timeout_hit_s;

   // Addresses and patterns for the current and the following index.
   always_comb begin
      idx_inc_s  = idx_r + IDX_ONE;
      last_s     = (idx_inc_s == num_r);
      word_cur_s = base_r + idx_r[ADDR_W-1:0];
      word_inc_s = base_r + idx_inc_s[ADDR_W-1:0];
      pat_cur_s  = DATA_W'(pat(64'(seed_r), 64'(idx_r)));
      pat_inc_s  = DATA_W'(pat(64'(seed_r), 64'(idx_inc_s)));
      in_wait_s  = (state_r == RD_WAIT);
   end

   // Next-state and next-output logic; bus outputs are registered so the
   // next request is prepared here to keep writes back-to-back.
   always_comb begin
      state_nxt_s = state_r;
      idx_nxt_s   = idx_r;
      base_nxt_s  = base_r;
      num_nxt_s   = num_r;
      seed_nxt_s  = seed_r;
      addr_nxt_s  = avm_address_r;
      data_nxt_s  = avm_writedata_r;
      wr_nxt_s    = avm_write_r;
      rd_nxt_s    = avm_read_r;
      pass_nxt_s  = pass_r;
      clear_s     = 1'b0;
      arm_s       = 1'b0;
      case (state_r)
         IDLE: begin
            if (start) begin
               clear_s = 1'b1;
               if (num_words == IDX_ZERO) begin
                  state_nxt_s = FIN;
                  pass_nxt_s  = 1'b1;
               end else begin
                  state_nxt_s = WR;
                  pass_nxt_s  = 1'b0;
                  base_nxt_s  = base_addr;
                  num_nxt_s   = num_words;
                  seed_nxt_s  = seed;
                  idx_nxt_s   = IDX_ZERO;
                  addr_nxt_s  = {base_addr, 2'b00};
                  data_nxt_s  = seed;
                  wr_nxt_s    = 1'b1;
               end
            end else begin
               state_nxt_s = IDLE;
            end
         end
         WR: begin
            if (!avm_waitrequest) begin
               if (last_s) begin
                  state_nxt_s = RD_REQ;
                  idx_nxt_s   = IDX_ZERO;
                  addr_nxt_s  = {base_r, 2'b00};
                  wr_nxt_s    = 1'b0;
                  rd_nxt_s    = 1'b1;
               end else begin
                  idx_nxt_s   = idx_inc_s;
                  addr_nxt_s  = {word_inc_s, 2'b00};
                  data_nxt_s  = pat_inc_s;
               end
            end else begin
               state_nxt_s = WR;
            end
         end
         RD_REQ: begin
            if (!avm_waitrequest) begin
               state_nxt_s = RD_WAIT;
               rd_nxt_s    = 1'b0;
               arm_s       = 1'b1;
            end else begin
               state_nxt_s = RD_REQ;
            end
         end
         RD_WAIT: begin
            if (avm_readdatavalid) begin
               if (last_s) begin
                  state_nxt_s = FIN;
                  // err_count has not yet absorbed this cycle's compare.
                  pass_nxt_s  = (err_count == {ERR_W{1'b0}}) && !mismatch_s;
               end else begin
                  state_nxt_s = RD_REQ;
                  idx_nxt_s   = idx_inc_s;
                  addr_nxt_s  = {word_inc_s, 2'b00};
                  rd_nxt_s    = 1'b1;
               end
            end else if (timeout_hit_s) begin
               state_nxt_s = FIN;
               pass_nxt_s  = 1'b0;
            end else begin
               state_nxt_s = RD_WAIT;
            end
         end
         FIN: begin
            state_nxt_s = IDLE;
         end
         default: begin
            state_nxt_s = IDLE;
            wr_nxt_s    = 1'b0;
            rd_nxt_s    = 1'b0;
         end
      endcase
      done_nxt_s = (state_nxt_s == FIN);
      busy_nxt_s = (state_nxt_s == WR) || (state_nxt_s == RD_REQ) || (state_nxt_s == RD_WAIT);
   end

   // State and registered outputs.
   always_ff @(posedge clk or negedge reset_n) begin
      if (!reset_n) begin
         state_r         <= IDLE;
         idx_r           <= IDX_ZERO;
         base_r          <= {ADDR_W{1'b0}};
         num_r           <= IDX_ZERO;
         seed_r          <= {DATA_W{1'b0}};
         busy_r          <= 1'b0;
         done_r          <= 1'b0;
         pass_r          <= 1'b0;
         avm_address_r   <= {(ADDR_W+2){1'b0}};
         avm_read_r      <= 1'b0;
         avm_write_r     <= 1'b0;
         avm_writedata_r <= {DATA_W{1'b0}};
      end else begin
         state_r         <= state_nxt_s;
         idx_r           <= idx_nxt_s;
         base_r          <= base_nxt_s;
         num_r           <= num_nxt_s;
         seed_r          <= seed_nxt_s;
         busy_r          <= busy_nxt_s;
         done_r          <= done_nxt_s;
         pass_r          <= pass_nxt_s;
         avm_address_r   <= addr_nxt_s;
         avm_read_r      <= rd_nxt_s;
         avm_write_r     <= wr_nxt_s;
         avm_writedata_r <= data_nxt_s;
      end
   end

   avalon_mm_tester_checker #(
      .ADDR_W  (ADDR_W),
      .DATA_W  (DATA_W),
      .ERR_W   (ERR_W),
      .TIMEOUT (TIMEOUT)
   ) u_checker (
      .clk            (clk),
      .rst_n          (reset_n),
      .clear          (clear_s),
      .arm            (arm_s),
      .in_wait        (in_wait_s),
      .rdv            (avm_readdatavalid),
      .rdata          (avm_readdata),
      .exp_data       (pat_cur_s),
      .word_addr      (word_cur_s),
      .err_count      (err_count),
      .first_err_addr (first_err_addr),
      .timeout        (timeout),
      .mismatch       (mismatch_s),
      .timeout_hit    (timeout_hit_s)
   );

   assign busy           = busy_r;
   assign done           = done_r;
   assign pass           = pass_r;
   assign avm_address    = avm_address_r;
   assign avm_read       = avm_read_r;
   assign avm_write      = avm_write_r;
   assign avm_writedata  = avm_writedata_r;
   assign avm_byteenable = BYTEEN_ALL[DATA_W/8-1:0];

endmodule
